ssd_page_scheduler: RTL and testbench

//  Sequences which game value the 4-digit SSD shows. Pages: points, high score,

---
 rtl/ssd_page_scheduler_pkg.sv | 18 +
 rtl/ssd_tick_gen.sv | 20 ++
 rtl/ssd_page_scheduler.sv | 141 ++++++++++++++
 tb/tb_ssd_page_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_page_scheduler_pkg.sv
// Shared page and state codes for the SSD page scheduler.
package ssd_page_scheduler_pkg;

    typedef enum logic [1:0] {
        PG_PTS   = 2'd0,
        PG_HPTS  = 2'd1,
        PG_TIME  = 2'd2,
        PG_ROUND = 2'd3
    } page_t;

    // 2'b11 is unused and recovers to ST_SHOW.
    typedef enum logic [1:0] {
        ST_SHOW   = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ALERT  = 2'd2
    } state_t;

endpackage

// File: rtl/ssd_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks.
module ssd_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/ssd_page_scheduler.sv
// Chooses which game value the SSD shows: auto-rotate, manual advance,
// pause blinking and a timed new-high-score alert that pre-empts both.
module ssd_page_scheduler
    import ssd_page_scheduler_pkg::*;
#(
    parameter int TICK_DIV   = 100_000_000,
    parameter int BLINK_DIV  = 50_000_000,
    parameter int ROTATE_SEC = 3,
    parameter int ALERT_SEC  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pause,
    input  logic        adv,
    input  logic        auto_en,
    input  logic        new_high,
    input  logic [15:0] pts,
    input  logic [15:0] hpts,
    input  logic [15:0] times,
    input  logic [15:0] rounds,
    output logic [15:0] display_number,
    output logic [1:0]  page,
    output logic        blank,
    output logic        alert
);
    localparam int RW = (ROTATE_SEC > 1) ? $clog2(ROTATE_SEC) : 1;
    localparam int AW = (ALERT_SEC > 1) ? $clog2(ALERT_SEC) : 1;

    logic sec_tick, blink_tick;

    ssd_tick_gen #(.DIV(TICK_DIV))  u_sec   (.clk(clk), .rst(rst), .tick(sec_tick));
    ssd_tick_gen #(.DIV(BLINK_DIV)) u_blink (.clk(clk), .rst(rst), .tick(blink_tick));

    state_t        state, state_n;
    page_t         page_q, page_n, saved_q, saved_n;
    logic          blank_q, blank_n, alert_q, alert_n;
    logic [RW-1:0] rot_cnt, rot_n;
    logic [AW-1:0] alr_cnt, alr_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_SHOW;
            page_q  <= PG_PTS;
            saved_q <= PG_PTS;
            blank_q <= 1'b0;
            alert_q <= 1'b0;
            rot_cnt <= '0;
            alr_cnt <= '0;
        end else begin
            state   <= state_n;
            page_q  <= page_n;
            saved_q <= saved_n;
            blank_q <= blank_n;
            alert_q <= alert_n;
            rot_cnt <= rot_n;
            alr_cnt <= alr_n;
        end
    end

    always_comb begin
        state_n = state;
        page_n  = page_q;
        saved_n = saved_q;
        blank_n = blank_q;
        alert_n = alert_q;
        rot_n   = rot_cnt;
        alr_n   = alr_cnt;
        case (state)
            ST_SHOW, ST_PAUSED: begin
                if (new_high) begin
                    saved_n = page_q;
                    page_n  = PG_HPTS;
                    alert_n = 1'b1;
                    alr_n   = '0;
                    blank_n = 1'b0;
                    state_n = ST_ALERT;
                end else if (state == ST_SHOW) begin
                    if (pause) begin
                        state_n = ST_PAUSED;
                    end else if (adv) begin
                        page_n = page_t'(page_q + 2'd1);
                        rot_n  = '0;
                    end else if (auto_en && sec_tick) begin
                        if (rot_cnt == RW'(ROTATE_SEC - 1)) begin
                            page_n = page_t'(page_q + 2'd1);
                            rot_n  = '0;
                        end else begin
                            rot_n = rot_cnt + 1'b1;
                        end
                    end
                end else if (!pause) begin
                    state_n = ST_SHOW;
                    blank_n = 1'b0;
                    rot_n   = '0;
                end else begin
                    if (adv)        page_n  = page_t'(page_q + 2'd1);
                    if (blink_tick) blank_n = ~blank_q;
                end
            end
            ST_ALERT: begin
                if (blink_tick) blank_n = ~blank_q;
                // A repeated new_high only restarts the hold; the saved page stays.
                if (new_high) begin
                    alr_n = '0;
                end else if (sec_tick) begin
                    if (alr_cnt == AW'(ALERT_SEC - 1)) begin
                        page_n  = saved_q;
                        alert_n = 1'b0;
                        blank_n = 1'b0;
                        rot_n   = '0;
                        state_n = pause ? ST_PAUSED : ST_SHOW;
                    end else begin
                        alr_n = alr_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_SHOW;
                blank_n = 1'b0;
                alert_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            display_number <= '0;
        end else begin
            case (page_q)
                PG_PTS:  display_number <= pts;
                PG_HPTS: display_number <= hpts;
                PG_TIME: display_number <= times;
                default: display_number <= rounds;
            endcase
        end
    end

    assign page  = page_q;
    assign blank = blank_q;
    assign alert = alert_q;
endmodule

// File: tb/tb_ssd_page_scheduler.sv
// Randomised and directed bench for ssd_page_scheduler against a rule-level model.
module tb_ssd_page_scheduler;
    localparam int TD = 4, BD = 2, RS = 3, AS = 2;
    localparam int M_SHOW = 0, M_PAUSED = 1, M_ALERT = 2;

    logic clk = 1'b0, rst = 1'b0;
    logic pause = 1'b0, adv = 1'b0, auto_en = 1'b0, new_high = 1'b0;
    logic [15:0] pts = '0, hpts = '0, times = '0, rounds = '0;
    logic [15:0] display_number;
    logic [1:0]  page;
    logic        blank, alert;

    int errors = 0, checks = 0;

    ssd_page_scheduler #(.TICK_DIV(TD), .BLINK_DIV(BD), .ROTATE_SEC(RS), .ALERT_SEC(AS)) dut (
        .clk(clk), .rst(rst), .pause(pause), .adv(adv), .auto_en(auto_en),
        .new_high(new_high), .pts(pts), .hpts(hpts), .times(times), .rounds(rounds),
        .display_number(display_number), .page(page), .blank(blank), .alert(alert)
    );

    always #5 clk = ~clk;

    // Model: edge count since reset drives both ticks; rotation counts seconds
    // shown, the alert counts seconds remaining.
    int          m_cyc = 0, m_mode = M_SHOW, m_rot = 0, m_left = 0;
    logic [1:0]  m_page = '0, m_saved = '0;
    logic        m_blank = 1'b0, m_alert = 1'b0;
    logic [15:0] m_disp = '0;

    wire [19:0] obs  = {display_number, page, blank, alert};
    wire [19:0] expv = {m_disp, m_page, m_blank, m_alert};

    function automatic logic [15:0] pick(input logic [1:0] p);
        case (p)
            2'd0:    return pts;
            2'd1:    return hpts;
            2'd2:    return times;
            default: return rounds;
        endcase
    endfunction

    task automatic model_step();
        bit st, bt;
        logic [15:0] nd;
        m_cyc++;
        st = (m_cyc % TD) == 0;
        bt = (m_cyc % BD) == 0;
        nd = pick(m_page);
        if (m_mode == M_ALERT) begin
            if (new_high) m_left = AS;
            else if (st)  m_left--;
            if (m_left == 0) begin
                m_page = m_saved; m_alert = 0; m_blank = 0; m_rot = 0;
                m_mode = pause ? M_PAUSED : M_SHOW;
            end else if (bt) m_blank = !m_blank;
        end else if (new_high) begin
            m_saved = m_page; m_page = 2'd1; m_alert = 1; m_left = AS; m_blank = 0;
            m_mode = M_ALERT;
        end else if (m_mode == M_SHOW) begin
            if (pause) m_mode = M_PAUSED;
            else if (adv) begin m_page++; m_rot = 0; end
            else if (auto_en && st) begin
                m_rot++;
                if (m_rot == RS) begin m_page++; m_rot = 0; end
            end
        end else begin
            if (!pause) begin m_mode = M_SHOW; m_blank = 0; m_rot = 0; end
            else begin
                if (adv) m_page++;
                if (bt)  m_blank = !m_blank;
            end
        end
        m_disp = nd;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cyc = 0; m_mode = M_SHOW; m_rot = 0; m_left = 0; m_page = '0;
            m_saved = '0; m_blank = 0; m_alert = 0; m_disp = '0;
        end else model_step();
    end

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; auto_en = 1'b1; pts = 16'h0042;
        hpts = 16'h1111; times = 16'h0230; rounds = 16'h0007;
        repeat (7) cyc1();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs !== 20'h0) begin errors++; $display("FAIL reset_async got=%h exp=0", obs); end
        repeat (2) cyc1();
        checks++;
        if (obs !== 20'h0) begin errors++; $display("FAIL reset_hold got=%h exp=0", obs); end
        rst = 1'b1;
        checks++;
        if (page !== 2'd0 || display_number !== 16'h0) begin
            errors++; $display("FAIL reset_release page=%0d disp=%h exp 0/0000", page, display_number);
        end
        cyc1();
        checks++;
        if (display_number !== 16'h0042) begin
            errors++; $display("FAIL disp_latency got=%h exp=0042", display_number);
        end
        for (int e = 2; e <= 48; e++) begin
            cyc1();
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL rotate e=%0d got=%h exp=%h", e, obs, expv); end
            if (e % 12 == 0) begin
                logic [1:0] pe;
                pe = 2'(e / 12);
                checks++;
                if (page !== pe) begin errors++; $display("FAIL rotate_step e=%0d got=%0d exp=%0d", e, page, pe); end
            end
        end
    endtask

    task automatic test_adv_rotate();
        int n;
        logic [1:0] p0, pe;
        n = 0;
        while (!(m_mode == M_SHOW && m_rot == RS - 1 && (m_cyc + 1) % TD == 0) && n < 100) begin
            cyc1(); n++;
        end
        checks++;
        if (n >= 100) begin errors++; $display("FAIL adv_align timeout got=%0d exp<100", n); end
        p0 = page; pe = p0 + 2'd1;
        adv = 1'b1; cyc1(); adv = 1'b0;
        checks++;
        if (page !== pe) begin errors++; $display("FAIL adv_rot_once got=%0d exp=%0d", page, pe); end
        n = 0;
        while (page === pe && n < 40) begin cyc1(); n++; end
        checks++;
        if (n !== 12) begin errors++; $display("FAIL next_rot got=%0d exp=12", n); end
    endtask

    task automatic test_pause();
        int toggles, n;
        logic prev;
        logic [1:0] p0, pe;
        pause = 1'b1; cyc1();
        p0 = page;
        checks++;
        if (blank !== 1'b0) begin errors++; $display("FAIL pause_entry blank=%b exp=0", blank); end
        toggles = 0; prev = blank;
        repeat (40) begin
            cyc1();
            if (blank !== prev) toggles++;
            prev = blank;
            checks++;
            if (page !== p0 || obs !== expv) begin
                errors++; $display("FAIL pause_hold got=%h exp=%h page0=%0d", obs, expv, p0);
            end
        end
        checks++;
        if (toggles !== 20) begin errors++; $display("FAIL blink_toggles got=%0d exp=20", toggles); end
        pe = p0 + 2'd1;
        adv = 1'b1; cyc1(); adv = 1'b0;
        checks++;
        if (page !== pe) begin errors++; $display("FAIL pause_adv got=%0d exp=%0d", page, pe); end
        n = 0;
        while (blank !== 1'b1 && n < 4) begin cyc1(); n++; end
        pause = 1'b0; cyc1();
        checks++;
        if (blank !== 1'b0 || obs !== expv) begin
            errors++; $display("FAIL unpause_blank got=%h exp=%h", obs, expv);
        end
    endtask

    task automatic test_alert();
        int n, exit_k, t, expk;
        auto_en = 1'b0; pause = 1'b0;
        n = 0;
        while (page !== 2'd3 && n < 8) begin adv = 1'b1; cyc1(); adv = 1'b0; n++; end
        n = 0;
        while ((m_cyc + 1) % TD != 0 && n < 8) begin cyc1(); n++; end
        new_high = 1'b1; cyc1(); new_high = 1'b0;
        checks++;
        if (page !== 2'd1 || alert !== 1'b1) begin
            errors++; $display("FAIL alert_entry page=%0d alert=%b exp 1/1", page, alert);
        end
        for (int k = 1; k <= 8; k++) begin
            adv = k[0];
            cyc1();
            checks++;
            if (k < 8 && (alert !== 1'b1 || page !== 2'd1)) begin
                errors++; $display("FAIL alert_hold k=%0d page=%0d alert=%b exp 1/1", k, page, alert);
            end else if (k == 8 && (alert !== 1'b0 || page !== 2'd3)) begin
                errors++; $display("FAIL alert_exit page=%0d alert=%b exp 3/0", page, alert);
            end
        end
        adv = 1'b0;
        n = 0;
        while ((m_cyc + 1) % TD != 0 && n < 8) begin cyc1(); n++; end
        new_high = 1'b1; cyc1(); new_high = 1'b0;
        exit_k = -1;
        for (int k = 1; k <= 20 && exit_k < 0; k++) begin
            new_high = (k == 5);
            cyc1();
            if (alert === 1'b0) exit_k = k;
        end
        new_high = 1'b0;
        t = 6;
        while (t % TD != 0) t++;
        expk = t + TD * (AS - 1);
        checks++;
        if (exit_k !== expk || page !== 2'd3) begin
            errors++; $display("FAIL alert_extend exit=%0d page=%0d exp %0d/3", exit_k, page, expk);
        end
    endtask

    task automatic test_alert_pause();
        int n;
        logic [1:0] p0;
        pause = 1'b1; cyc1(); cyc1();
        p0 = page;
        new_high = 1'b1; cyc1(); new_high = 1'b0;
        checks++;
        if (alert !== 1'b1) begin errors++; $display("FAIL alert_pause_entry alert=%b exp=1", alert); end
        pause = 1'b0;
        n = 0;
        while (alert === 1'b1 && n < 20) begin cyc1(); n++; end
        checks++;
        if (alert !== 1'b0 || blank !== 1'b0 || page !== p0) begin
            errors++; $display("FAIL alert_pause_exit alert=%b blank=%b page=%0d exp 0/0/%0d", alert, blank, page, p0);
        end
        repeat (4) begin
            cyc1();
            checks++;
            if (blank !== 1'b0 || obs !== expv) begin
                errors++; $display("FAIL show_after_alert got=%h exp=%h", obs, expv);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(29) == 0) pause = ~pause;
            if ($urandom_range(49) == 0) auto_en = ~auto_en;
            adv      = ($urandom_range(9) == 0);
            new_high = ($urandom_range(39) == 0);
            if ($urandom_range(7) == 0) pts    = 16'($urandom);
            if ($urandom_range(7) == 0) hpts   = 16'($urandom);
            if ($urandom_range(7) == 0) times  = 16'($urandom);
            if ($urandom_range(7) == 0) rounds = 16'($urandom);
            cyc1();
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL random i=%0d got=%h exp=%h", i, obs, expv); end
        end
        adv = 1'b0; new_high = 1'b0;
    endtask

    initial begin
        repeat (2) cyc1();
        test_reset();
        test_adv_rotate();
        test_pause();
        test_alert();
        test_alert_pause();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
